// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the RV32 M-extension sequencer
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } mdu_state_e;

   localparam int          DIV_ITERS = 32;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

   // Magnitude of a possibly-signed operand; INT_MIN maps to 0x80000000 unsigned.
   function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
// quo holds the remaining dividend bits MSB-first; quotient bits shift in at the bottom.
module mdu_div_step (
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] divisor,
   output logic [31:0] rem_next,
   output logic [31:0] quo_next
);

   logic [32:0] shifted;
   logic        fits;

   always_comb begin
      shifted  = {rem, quo[31]};
      fits     = shifted >= {1'b0, divisor};
      // The difference is below divisor, so the low 32 bits carry the whole value.
      rem_next = fits ? (shifted[31:0] - divisor) : shifted[31:0];
      quo_next = {quo[30:0], fits};
   end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - RV32 M-extension multiply/divide sequencer with valid/ready handshakes
// Optional divide result reuse stash enabled by MDU_DIVREM_REUSE_EN.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_x,
   input  logic [XLEN-1:0] i_y,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy
);

   mdu_state_e state, state_nxt;
   mdu_op_e    op_q;
   logic [4:0] cnt;
   logic [XLEN-1:0] x_q, y_q, quo_q, rem_q, div_q, result_q;
   logic       neg_q, rneg_q, hit_q;

   logic       accept, in_signed, div_zero, div_ovf, special;
   logic [XLEN-1:0] special_val;
   logic       stash_hit;
   logic [XLEN-1:0] stash_val;
   logic [XLEN-1:0] step_rem, step_quo;
   logic [XLEN-1:0] fix_quo, fix_rem, fix_res, mul_res;
   logic       mul_sx, mul_sy;
   logic [63:0] mul_a, mul_b, prod;

   assign accept      = i_valid && (state == ST_IDLE) && !i_flush;
   assign in_signed   = ~i_op[0];
   assign div_zero    = (i_y == '0);
   assign div_ovf     = in_signed && (i_x == INT_MIN) && (i_y == ALL_ONES);
   assign special     = i_op[2] && (div_zero || div_ovf);
   assign special_val = div_zero ? (i_op[1] ? i_x : ALL_ONES)
                                 : (i_op[1] ? '0  : INT_MIN);

   // Sign-extend to 64 bits so the low 64 product bits are exact for every signedness mix.
   assign mul_sx  = (op_q != OP_MULHU);
   assign mul_sy  = (op_q == OP_MUL) || (op_q == OP_MULH);
   assign mul_a   = {{32{mul_sx & x_q[31]}}, x_q};
   assign mul_b   = {{32{mul_sy & y_q[31]}}, y_q};
   assign prod    = mul_a * mul_b;
   assign mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];

   assign fix_quo = neg_q  ? (~quo_q + 32'd1) : quo_q;
   assign fix_rem = rneg_q ? (~rem_q + 32'd1) : rem_q;
   assign fix_res = op_q[1] ? fix_rem : fix_quo;

   mdu_div_step u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (div_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

`ifdef MDU_DIVREM_REUSE_EN
   logic [XLEN-1:0] st_x, st_y, st_quo, st_rem;
   logic            st_signed, st_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         st_valid  <= 1'b0;
         st_signed <= 1'b0;
         st_x      <= '0;
         st_y      <= '0;
         st_quo    <= '0;
         st_rem    <= '0;
      end else if (state == ST_FIX && !i_flush) begin
         st_valid  <= 1'b1;
         st_signed <= ~op_q[0];
         st_x      <= x_q;
         st_y      <= y_q;
         st_quo    <= fix_quo;
         st_rem    <= fix_rem;
      end
   end

   assign stash_hit = st_valid && (i_x == st_x) && (i_y == st_y) && (in_signed == st_signed);
   assign stash_val = op_q[1] ? st_rem : st_quo;
`else
   assign stash_hit = 1'b0;
   assign stash_val = '0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!i_op[2])       state_nxt = ST_MUL;
               else if (special)   state_nxt = ST_DONE;
               else if (stash_hit) state_nxt = ST_MUL;
               else                state_nxt = ST_DIV;
            end
         end
         ST_MUL:  state_nxt = ST_DONE;
         ST_DIV:  if (cnt == 5'(DIV_ITERS - 1)) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_DONE;
         ST_DONE: if (i_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (i_flush) state_nxt = ST_IDLE;
   end

   always_comb begin
      o_ready  = (state == ST_IDLE);
      o_valid  = (state == ST_DONE);
      o_busy   = (state != ST_IDLE);
      o_result = result_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         op_q     <= OP_MUL;
         cnt      <= '0;
         x_q      <= '0;
         y_q      <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         hit_q    <= 1'b0;
         result_q <= '0;
      end else if (!i_flush) begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q   <= mdu_op_e'(i_op);
                  x_q    <= i_x;
                  y_q    <= i_y;
                  cnt    <= '0;
                  rem_q  <= '0;
                  quo_q  <= mag(i_x, in_signed);
                  div_q  <= mag(i_y, in_signed);
                  neg_q  <= in_signed && (i_x[31] ^ i_y[31]);
                  rneg_q <= in_signed && i_x[31];
                  hit_q  <= i_op[2] && !special && stash_hit;
                  if (special) result_q <= special_val;
               end
            end
            ST_MUL:  result_q <= hit_q ? stash_val : mul_res;
            ST_DIV: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt   <= cnt + 5'd1;
            end
            ST_FIX:  result_q <= fix_res;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq
// Reuse latency expectations follow MDU_DIVREM_REUSE_EN.
module tb_mdu_seq;

`ifdef MDU_DIVREM_REUSE_EN
   localparam int RL = 2;
`else
   localparam int RL = 34;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [2:0]  op = 3'd0;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic        flush = 1'b0;
   logic        valid_out;
   logic        ready_in = 1'b0;
   logic [31:0] result;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   mdu_seq #(.XLEN(32)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (valid_in),
      .o_ready  (ready_out),
      .i_op     (op),
      .i_x      (x),
      .i_y      (y),
      .i_flush  (flush),
      .o_valid  (valid_out),
      .i_ready  (ready_in),
      .o_result (result),
      .o_busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one request; lat counts edges from the accept edge (inclusive) to o_valid.
   task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      valid_in = 1'b1; op = o; x = a; y = b;
      @(posedge clk); #1;
      valid_in = 1'b0; op = 3'd0; x = 32'hDEAD_BEEF; y = 32'h0BAD_F00D;
      lat = 1;
      while (!valid_out && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take();
      @(negedge clk);
      ready_in = 1'b1;
      @(posedge clk); #1;
      ready_in = 1'b0;
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input int exp_lat);
      int lat;
      send(o, a, b, lat);
      check_eq({tag, "_res"}, 64'(result), 64'(exp_res));
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      take();
      check_eq({tag, "_rdy"}, 64'(ready_out), 64'd1);
   endtask

   task automatic abort_div(input bit use_rst, input logic [31:0] prev_res);
      bit seen;
      @(negedge clk);
      valid_in = 1'b1; op = 3'b100; x = 32'd12345; y = 32'd67;
      @(posedge clk); #1;
      valid_in = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      if (use_rst) rst = 1'b1; else flush = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0;
      check_eq(use_rst ? "rst_state" : "flush_state", {61'd0, ready_out, busy, valid_out}, {61'd0, 3'b100});
      check_eq(use_rst ? "rst_result" : "flush_result", 64'(result), 64'(prev_res));
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (valid_out) seen = 1'b1;
      end
      check_eq(use_rst ? "rst_no_valid" : "flush_no_valid", 64'(seen), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("reset_state", {60'd0, ready_out, valid_out, busy, 1'b0}, {60'd0, 4'b1000});
      check_eq("reset_result", 64'(result), 64'd0);

      run("mulh",   3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 2);
      run("mulhu",  3'b011, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 2);
      run("mul",    3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 2);
      run("mulhsu", 3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 2);

      run("div_s",  3'b100, 32'd7,   32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      run("rem_s",  3'b110, 32'd7,   32'hFFFF_FFFE, 32'h0000_0001, RL);
      run("divu",   3'b101, 32'd100, 32'd7,         32'd14,        34);
      run("remu",   3'b111, 32'd100, 32'd7,         32'd2,         RL);

      run("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run("remu_z", 3'b111, 32'd5, 32'd0, 32'd5,         1);
      run("div_z",  3'b100, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
      run("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      begin : backpressure
         int lat;
         send(3'b000, 32'd3, 32'd5, lat);
         check_eq("bp_lat", 64'(lat), 64'd2);
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", {30'd0, valid_out, ready_out, result}, {30'd0, 2'b10, 32'd15});
         end
         @(negedge clk);
         ready_in = 1'b1;
         @(posedge clk); #1;
         ready_in = 1'b0;
         check_eq("bp_release", {62'd0, ready_out, valid_out}, {62'd0, 2'b10});
      end

      abort_div(1'b0, 32'd15);
      run("mul_after_flush", 3'b000, 32'd6, 32'd7, 32'd42, 2);
      abort_div(1'b1, 32'd0);
      run("mul_after_rst",   3'b000, 32'd6, 32'd7, 32'd42, 2);

      run("div_1000", 3'b100, 32'd1000, 32'd7, 32'd142, 34);
      run("rem_1000", 3'b110, 32'd1000, 32'd7, 32'd6,   RL);
      run("remu_1000", 3'b111, 32'd1000, 32'd7, 32'd6,  34);
      run("div_neg",  3'b100, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 34);
      run("rem_neg",  3'b110, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FFFA, RL);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer for the RV32 M-extension.
- Takes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request at a time from the execute stage over a valid/ready handshake.
- Multiplies in a single registered step; divides with an internal 32-iteration restoring divider.
- Returns the result over a second valid/ready handshake, and stalls the pipeline while busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  request accepted when i_valid && o_ready.
- i_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_x  input  XLEN  rs1 operand.
- i_y  input  XLEN  rs2 operand.
- i_flush  input  1  abort any in-flight op; no result is produced.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer takes result when o_valid && i_ready.
- o_result  output  XLEN  result.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: i_rst is synchronous and active-high; it dominates i_flush and all other inputs. After reset: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_busy=0, iteration counter=0.
- Acceptance: o_ready=1 only in IDLE. i_op, i_x and i_y are latched on the accept edge and are ignored in every other state.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE transitions on accept: to MUL for ops 0xx; to DONE for a divide special case; otherwise to DIV.
- MUL: one cycle. Computes the 64-bit product, then goes to DONE.
  - Operand extension: MUL/MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned x unsigned.
  - MUL returns prod[31:0]; the other three return prod[63:32].
  - Latency: o_valid is visible 2 edges after the accept edge.
- DIV: operates on magnitudes.
  - Signed ops use |x| and |y|; the quotient is negated when the operand signs differ; the remainder takes the sign of x.
  - One restoring step per cycle, counter 0..31; after the step at count 31, go to FIX.
- FIX: applies the sign corrections, selects quotient (DIV/DIVU) or remainder (REM/REMU), then goes to DONE.
  - Latency: o_valid is visible 34 edges after the accept edge.
- Special cases (decided at accept, go straight to DONE, latency 1 edge):
  - y==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return x.
  - Signed overflow (x==0x80000000, y==0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE: o_valid=1 and o_result held stable until i_ready. When o_valid && i_ready, go to IDLE. A new request cannot be accepted in the same cycle the result is taken.
- Flush: i_flush in any state forces IDLE on the next edge, with o_valid=0. o_result is not cleared. An i_flush in IDLE blocks an accept in that cycle.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: MDU_DIVREM_REUSE_EN.
- Defined:
  - A stash holds {x, y, signedness, quotient, remainder, stash_valid}.
  - It is written when a full iterative divide reaches FIX.
  - stash_valid is cleared only by reset.
  - A divide request whose x, y and signedness (DIV/REM vs DIVU/REMU) match a valid stash goes IDLE->MUL-timed path->DONE and returns the stashed quotient or remainder. Latency is 2 edges and no iteration runs.
  - Special cases are unaffected.
- Undefined: no stash logic; every non-special divide takes 34 edges.

Decomposition:
- Shared package mdu_pkg holds:
  - mdu_op_e enum for funct3 encodings.
  - mdu_state_e enum.
  - Constants DIV_ITERS=32, INT_MIN=32'h80000000, ALL_ONES=32'hFFFFFFFF.
- One sub-module, mdu_div_step: combinational single restoring step, inputs {rem, quo, divisor}, outputs the next {rem, quo}.
- The top level owns the FSM, counter, sign fix, multiply and stash.

Test Plan:
- MULH x=0xFFFFFFFE (-2), y=3 -> o_result=0xFFFFFFFF, o_valid 2 edges after accept; MULHU same operands -> 0x00000002; MUL -> 0xFFFFFFFA.
- DIV x=7, y=0xFFFFFFFE (-2) -> 0xFFFFFFFD after 34 edges; REM same operands -> 0x00000001; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Each valid 1 edge after accept.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid -> o_valid and o_result stable, o_ready=0; raise i_ready -> IDLE next edge, o_ready=1.
- Flush and reset mid-operation:
  - Assert i_flush 10 cycles into a DIV -> o_valid never rises, o_ready=1 after one edge; a following MUL 6*7 returns 42.
  - Repeat with i_rst instead of i_flush -> identical outcome.
- With MDU_DIVREM_REUSE_EN: DIV 1000/7 (34 edges, 142), then REM 1000/7 -> 6 in 2 edges; REMU 1000/7 -> full 34 edges. Without the macro, all three take 34 edges.
